alu_result_fifo: RTL

//  Downstream capture stage for the 5-bit ALU (X/Y/S -> F/Cout/Overflow).

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_result_fifo_if.sv | 39 +++
 rtl/sat_counter.sv | 29 ++
 rtl/alu_result_fifo.sv | 97 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, result width and the captured-entry layout.
package alu_pkg;

    localparam int F_W = 5;

    localparam logic [1:0] SEL_MUL  = 2'b00;
    localparam logic [1:0] SEL_CMP  = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_SUB4 = 2'b11;

    typedef struct packed {
        logic [1:0]     sel;
        logic           ovf;
        logic           cout;
        logic [F_W-1:0] f;
    } alu_entry_t;

    typedef enum logic [2:0] {
        ST_EMPTY   = 3'b001,
        ST_PARTIAL = 3'b010,
        ST_FULL    = 3'b100
    } fifo_st_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Push/pop handshake plus overflow statistics between the ALU, the result FIFO and its reader.
interface alu_result_fifo_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    import alu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_sel;
    logic [F_W-1:0] in_f;
    logic           in_cout;
    logic           in_ovf;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_sel;
    logic [F_W-1:0] out_f;
    logic           out_cout;
    logic           out_ovf;
    logic [CW-1:0]  count;
    logic           clr_stat;
    logic           sticky_ovf;
    logic [CNT_W-1:0] ovf_events;

    modport slave (
        input  in_valid, in_sel, in_f, in_cout, in_ovf, out_ready, clr_stat,
        output in_ready, out_valid, out_sel, out_f, out_cout, out_ovf, count,
               sticky_ovf, ovf_events
    );

    modport master (
        output in_valid, in_sel, in_f, in_cout, in_ovf, out_ready, clr_stat,
        input  in_ready, out_valid, out_sel, out_f, out_cout, out_ovf, count,
               sticky_ovf, ovf_events
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the clear cycle restarts at 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            if (i_clr)
                r_cnt <= {{(W-1){1'b0}}, 1'b1};
            else if (r_cnt != {W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end else if (i_clr) begin
            r_cnt <= '0;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/alu_result_fifo.sv
// Captures ALU results into a small FIFO read via valid/ready, with sticky overflow and event count.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_fifo_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    alu_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_sticky;

    fifo_st_t   w_status;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    alu_entry_t w_in;
    alu_entry_t w_head;

    always_comb begin
        w_status = ST_PARTIAL;
        if (r_count == '0)
            w_status = ST_EMPTY;
        else if (r_count == CW'(DEPTH))
            w_status = ST_FULL;
    end

    assign w_full  = (w_status == ST_FULL);
    assign w_empty = (w_status == ST_EMPTY);

    // Acceptance looks only at occupancy, so a pop cannot free a slot for a same-cycle push.
    assign w_push = bus.in_valid & ~w_full;
    assign w_pop  = bus.out_ready & ~w_empty;

    assign w_in = '{sel: bus.in_sel, ovf: bus.in_ovf, cout: bus.in_cout, f: bus.in_f};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_in;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sticky <= 1'b0;
        else if (w_push && bus.in_ovf)
            r_sticky <= 1'b1;
        else if (bus.clr_stat)
            r_sticky <= 1'b0;
    end

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_push & bus.in_ovf),
        .i_clr (bus.clr_stat),
        .o_cnt (bus.ovf_events)
    );

    assign w_head = r_mem[r_rptr];

    assign bus.in_ready   = ~w_full;
    assign bus.out_valid  = ~w_empty;
    assign bus.out_sel    = w_head.sel;
    assign bus.out_f      = w_head.f;
    assign bus.out_cout   = w_head.cout;
    assign bus.out_ovf    = w_head.ovf;
    assign bus.count      = r_count;
    assign bus.sticky_ovf = r_sticky;

endmodule
